// File: rtl/wb_bus_decoder.sv
// Registered Wishbone address decoder: routes one master to N_SLV windowed slaves or a
// default port, with per-slave wait states, slave-driven ack and a bus timeout with error log.
module wb_bus_decoder #(
   parameter int                  N_SLV    = 4,
   parameter int                  DW       = 32,
   parameter logic [N_SLV*32-1:0] SLV_BASE = {N_SLV{32'h0}},
   parameter logic [N_SLV*32-1:0] SLV_MASK = {N_SLV{32'hFFFF0000}},
   parameter logic [N_SLV*4-1:0]  SLV_WAIT = {N_SLV{4'h0}},
   parameter int unsigned         TIMEOUT  = 255,
   parameter logic [DW-1:0]       ERR_DATA = DW'(32'hBADACCE5)
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic [31:0]         m_adr,
   input  logic [DW-1:0]       m_dat_w,
   input  logic [DW/8-1:0]     m_sel,
   input  logic                m_we,
   input  logic                m_cyc,
   input  logic                m_stb,
   output logic [DW-1:0]       m_dat_r,
   output logic                m_ack,
   output logic                m_err,
   output logic [31:0]         s_adr,
   output logic [DW-1:0]       s_dat_w,
   output logic [DW/8-1:0]     s_sel,
   output logic [N_SLV-1:0]    s_rd,
   output logic [N_SLV-1:0]    s_wr,
   input  logic [N_SLV*DW-1:0] s_dat_r,
   input  logic [N_SLV-1:0]    s_ack,
   output logic                d_cyc,
   output logic                d_stb,
   output logic                d_we,
   input  logic [DW-1:0]       d_dat_r,
   input  logic                d_ack,
   output logic [7:0]          err_cnt,
   output logic [31:0]         err_adr
);

   localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      SACK = 3'd2,
      DFLT = 3'd3,
      RESP = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [31:0]       tcnt_q, tcnt_d;
   logic              first_q, first_d;
   logic [31:0]       s_adr_q, s_adr_d;
   logic [DW-1:0]     s_dat_w_q, s_dat_w_d;
   logic [DW/8-1:0]   s_sel_q, s_sel_d;
   logic              d_we_q, d_we_d;
   logic [DW-1:0]     m_dat_r_q, m_dat_r_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [31:0]       err_adr_q, err_adr_d;

   logic              hit;
   logic [IW-1:0]     hit_idx;
   logic [3:0]        hit_wait;
   logic              sel_ack;
   logic [DW-1:0]     sel_dat;
   logic [N_SLV-1:0]  slot_oh;
   logic              strobe_on;
   logic              tmo_hit;

   // Descending scan so the lowest matching window is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_wait = 4'h0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if ((m_adr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            hit      = 1'b1;
            hit_idx  = IW'(i);
            hit_wait = SLV_WAIT[4*i +: 4];
         end
      end
   end

   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      slot_oh = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (idx_q == IW'(i)) begin
            sel_ack    = s_ack[i];
            sel_dat    = s_dat_r[DW*i +: DW];
            slot_oh[i] = 1'b1;
         end
      end
   end

   assign tmo_hit = (TIMEOUT != 0) && (tcnt_q == TIMEOUT - 32'd1);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wcnt_d    = wcnt_q;
      tcnt_d    = tcnt_q;
      first_d   = 1'b0;
      s_adr_d   = s_adr_q;
      s_dat_w_d = s_dat_w_q;
      s_sel_d   = s_sel_q;
      d_we_d    = d_we_q;
      m_dat_r_d = m_dat_r_q;
      err_cnt_d = err_cnt_q;
      err_adr_d = err_adr_q;
      case (state_q)
         IDLE: begin
            if (m_cyc && m_stb) begin
               s_adr_d   = m_adr;
               s_dat_w_d = m_dat_w;
               s_sel_d   = m_sel;
               d_we_d    = m_we;
               idx_d     = hit_idx;
               first_d   = 1'b1;
               tcnt_d    = '0;
               if (!hit) begin
                  state_d = DFLT;
               end else if (hit_wait == 4'hF) begin
                  state_d = SACK;
               end else begin
                  state_d = WAIT;
                  wcnt_d  = hit_wait;
               end
            end
         end
         WAIT: begin
            if (!m_cyc) begin
               state_d = IDLE;
            end else if (wcnt_q == 4'd0) begin
               if (!d_we_q) m_dat_r_d = sel_dat;
               state_d = RESP;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         SACK, DFLT: begin
            // Abort beats ack, and an ack beats a timeout expiring on the same edge.
            if (!m_cyc) begin
               state_d = IDLE;
            end else if ((state_q == SACK) ? sel_ack : d_ack) begin
               if (!d_we_q) m_dat_r_d = (state_q == SACK) ? sel_dat : d_dat_r;
               state_d = RESP;
            end else if (tmo_hit) begin
               if (!d_we_q) m_dat_r_d = ERR_DATA;
               err_adr_d = s_adr_q;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               state_d = ERR;
            end else begin
               tcnt_d = tcnt_q + 32'd1;
            end
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wcnt_q    <= '0;
         tcnt_q    <= '0;
         first_q   <= 1'b0;
         s_adr_q   <= '0;
         s_dat_w_q <= '0;
         s_sel_q   <= '0;
         d_we_q    <= 1'b0;
         m_dat_r_q <= '0;
         err_cnt_q <= '0;
         err_adr_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wcnt_q    <= wcnt_d;
         tcnt_q    <= tcnt_d;
         first_q   <= first_d;
         s_adr_q   <= s_adr_d;
         s_dat_w_q <= s_dat_w_d;
         s_sel_q   <= s_sel_d;
         d_we_q    <= d_we_d;
         m_dat_r_q <= m_dat_r_d;
         err_cnt_q <= err_cnt_d;
         err_adr_q <= err_adr_d;
      end
   end

   // Slave strobes live only in the first cycle after acceptance.
   assign strobe_on = first_q && ((state_q == WAIT) || (state_q == SACK));
   assign s_rd      = (strobe_on && !d_we_q) ? slot_oh : '0;
   assign s_wr      = (strobe_on &&  d_we_q) ? slot_oh : '0;

   assign m_ack   = (state_q == RESP);
   assign m_err   = (state_q == ERR);
   assign d_cyc   = (state_q == DFLT);
   assign d_stb   = (state_q == DFLT);
   assign d_we    = d_we_q;
   assign m_dat_r = m_dat_r_q;
   assign s_adr   = s_adr_q;
   assign s_dat_w = s_dat_w_q;
   assign s_sel   = s_sel_q;
   assign err_cnt = err_cnt_q;
   assign err_adr = err_adr_q;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Directed bench for wb_bus_decoder: wait-state, slave-ack, default, timeout, abort and
// reset scenarios with hand-computed latencies and data.
module tb_wb_bus_decoder;

   logic         sys_clk = 1'b0;
   logic         rst;
   logic [31:0]  m_adr;
   logic [31:0]  m_dat_w;
   logic [3:0]   m_sel;
   logic         m_we;
   logic         m_cyc;
   logic         m_stb;
   logic [31:0]  m_dat_r;
   logic         m_ack;
   logic         m_err;
   logic [31:0]  s_adr;
   logic [31:0]  s_dat_w;
   logic [3:0]   s_sel;
   logic [3:0]   s_rd;
   logic [3:0]   s_wr;
   logic [127:0] s_dat_r;
   logic [3:0]   s_ack;
   logic         d_cyc;
   logic         d_stb;
   logic         d_we;
   logic [31:0]  d_dat_r;
   logic         d_ack;
   logic [7:0]   err_cnt;
   logic [31:0]  err_adr;

   wb_bus_decoder #(
      .N_SLV    (4),
      .DW       (32),
      .SLV_BASE ({32'h04000000, 32'h03000000, 32'h03400000, 32'h03300000}),
      .SLV_MASK ({32'hFFFF0000, 32'hFF000000, 32'hFFFF0000, 32'hFFFF0000}),
      .SLV_WAIT ({4'hF, 4'hF, 4'h3, 4'h0}),
      .TIMEOUT  (8),
      .ERR_DATA (32'hBADACCE5)
   ) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .m_adr   (m_adr),
      .m_dat_w (m_dat_w),
      .m_sel   (m_sel),
      .m_we    (m_we),
      .m_cyc   (m_cyc),
      .m_stb   (m_stb),
      .m_dat_r (m_dat_r),
      .m_ack   (m_ack),
      .m_err   (m_err),
      .s_adr   (s_adr),
      .s_dat_w (s_dat_w),
      .s_sel   (s_sel),
      .s_rd    (s_rd),
      .s_wr    (s_wr),
      .s_dat_r (s_dat_r),
      .s_ack   (s_ack),
      .d_cyc   (d_cyc),
      .d_stb   (d_stb),
      .d_we    (d_we),
      .d_dat_r (d_dat_r),
      .d_ack   (d_ack),
      .err_cnt (err_cnt),
      .err_adr (err_adr)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk = 0;
   int n_bad = 0;

   // Per-transfer observations
   int          r_lat;
   int          r_nresp;
   logic        r_ack;
   logic        r_err;
   logic [31:0] r_dat;
   int          r_rd_cnt;
   int          r_wr_cnt;
   logic [3:0]  r_rd_or;
   logic [3:0]  r_wr_or;
   int          r_dstb;
   logic [31:0] r_sdatw;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request; the slave/default ack is raised for the cycle numbered ack_at
   // (cycle 1 is the first cycle after the accepting edge), m_cyc drops after abort_at.
   task automatic run_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input int ack_at, input logic [3:0] ack_mask,
                           input int abort_at, input int max_cyc);
      r_lat = 0; r_nresp = 0; r_ack = 1'b0; r_err = 1'b0; r_dat = '0;
      r_rd_cnt = 0; r_wr_cnt = 0; r_rd_or = '0; r_wr_or = '0; r_dstb = 0; r_sdatw = '0;
      @(negedge sys_clk);
      m_adr = adr; m_we = we; m_dat_w = wdat; m_sel = 4'hF;
      m_cyc = 1'b1; m_stb = 1'b1;
      d_ack = (ack_at == 0) ? 1'b0 : 1'b0;
      @(posedge sys_clk);
      for (int n = 1; n <= max_cyc; n++) begin
         @(negedge sys_clk);
         m_stb = 1'b0;
         if (s_rd != 4'h0) begin r_rd_cnt++; r_rd_or |= s_rd; end
         if (s_wr != 4'h0) begin r_wr_cnt++; r_wr_or |= s_wr; r_sdatw = s_dat_w; end
         if (d_stb) r_dstb++;
         if (m_ack || m_err) begin
            r_nresp++;
            if (r_lat == 0) begin
               r_lat = n; r_ack = m_ack; r_err = m_err; r_dat = m_dat_r;
            end
            m_cyc = 1'b0;
         end
         if (n == abort_at) m_cyc = 1'b0;
         d_ack = (n == ack_at);
         s_ack = (n == ack_at) ? ack_mask : 4'h0;
      end
      m_cyc = 1'b0; d_ack = 1'b0; s_ack = 4'h0;
   endtask

   initial begin
      rst = 1'b1;
      m_adr = '0; m_dat_w = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
      s_ack = '0; d_ack = 1'b0;
      s_dat_r = {32'h33333333, 32'h22222222, 32'h11111111, 32'h12345678};
      d_dat_r = 32'hCAFEF00D;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_m_ack", {31'd0, m_ack}, 32'd0);
      check("rst_m_err", {31'd0, m_err}, 32'd0);
      check("rst_strobes", {24'd0, s_rd, s_wr}, 32'd0);
      check("rst_dport", {29'd0, d_cyc, d_stb, d_we}, 32'd0);
      check("rst_m_dat_r", m_dat_r, 32'd0);
      check("rst_s_adr", s_adr, 32'd0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      check("rst_err_adr", err_adr, 32'd0);
      rst = 1'b0;

      // Zero-wait read from slot 0
      run_xfer(32'h03300004, 1'b0, 32'h0, 0, 4'h0, 0, 5);
      check("w0_rd_once", r_rd_cnt, 1);
      check("w0_rd_slot", {28'd0, r_rd_or}, 32'h1);
      check("w0_no_wr", r_wr_cnt, 0);
      check("w0_lat", r_lat, 2);
      check("w0_ack", {31'd0, r_ack}, 32'd1);
      check("w0_one_resp", r_nresp, 1);
      check("w0_data", r_dat, 32'h12345678);

      // Three-wait write to slot 1
      run_xfer(32'h03400020, 1'b1, 32'hDEADBEEF, 0, 4'h0, 0, 8);
      check("w3_wr_once", r_wr_cnt, 1);
      check("w3_wr_slot", {28'd0, r_wr_or}, 32'h2);
      check("w3_wdata", r_sdatw, 32'hDEADBEEF);
      check("w3_no_rd", r_rd_cnt, 0);
      check("w3_lat", r_lat, 5);
      check("w3_dat_held", r_dat, 32'h12345678);
      check("w3_d_we", {31'd0, d_we}, 32'd1);

      // Default port read, ack in cycle 6
      run_xfer(32'h00001000, 1'b0, 32'h0, 6, 4'h0, 0, 10);
      check("df_dstb_cycles", r_dstb, 6);
      check("df_lat", r_lat, 7);
      check("df_ack", {31'd0, r_ack}, 32'd1);
      check("df_data", r_dat, 32'hCAFEF00D);
      check("df_no_strobe", r_rd_cnt + r_wr_cnt, 0);

      // Default port never answers: timeout
      run_xfer(32'h00200000, 1'b0, 32'h0, 0, 4'h0, 0, 12);
      check("to_lat", r_lat, 9);
      check("to_err", {31'd0, r_err}, 32'd1);
      check("to_no_ack", {31'd0, r_ack}, 32'd0);
      check("to_data", r_dat, 32'hBADACCE5);
      check("to_dstb_cycles", r_dstb, 8);
      check("to_one_resp", r_nresp, 1);
      check("to_err_cnt", {24'd0, err_cnt}, 32'd1);
      check("to_err_adr", err_adr, 32'h00200000);

      // Slave-acked read from slot 3
      run_xfer(32'h04000010, 1'b0, 32'h0, 4, 4'h8, 0, 8);
      check("sa_rd_slot", {28'd0, r_rd_or}, 32'h8);
      check("sa_rd_once", r_rd_cnt, 1);
      check("sa_lat", r_lat, 5);
      check("sa_data", r_dat, 32'h33333333);

      // Ack on the very edge the timeout expires
      run_xfer(32'h04000014, 1'b0, 32'h0, 8, 4'h8, 0, 12);
      check("late_lat", r_lat, 9);
      check("late_ack", {31'd0, r_ack}, 32'd1);
      check("late_no_err", {31'd0, r_err}, 32'd0);
      check("late_err_cnt", {24'd0, err_cnt}, 32'd1);

      // Overlapping windows 0/2: lowest index wins
      run_xfer(32'h03300008, 1'b0, 32'h0, 0, 4'h0, 0, 5);
      check("ov_rd_slot", {28'd0, r_rd_or}, 32'h1);
      check("ov_lat", r_lat, 2);
      check("ov_data", r_dat, 32'h12345678);

      // Abort in SACK on slot 2: no response at all, even past the timeout
      run_xfer(32'h03500000, 1'b0, 32'h0, 0, 4'h0, 3, 14);
      check("ab_rd_slot", {28'd0, r_rd_or}, 32'h4);
      check("ab_no_resp", r_nresp, 0);
      check("ab_err_cnt", {24'd0, err_cnt}, 32'd1);
      run_xfer(32'h03300004, 1'b0, 32'h0, 0, 4'h0, 0, 5);
      check("ab_next_lat", r_lat, 2);

      // Drive the error counter into saturation
      for (int k = 0; k < 299; k++) run_xfer(32'h00200000, 1'b0, 32'h0, 0, 4'h0, 0, 10);
      check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

      // Asynchronous reset in the middle of a default-port transfer
      @(negedge sys_clk);
      m_adr = 32'h00001000; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      m_stb = 1'b0;
      check("mr_dstb_before", {31'd0, d_stb}, 32'd1);
      @(posedge sys_clk);
      #2 rst = 1'b1;
      #1;
      check("mr_dport", {30'd0, d_cyc, d_stb}, 32'd0);
      check("mr_err_cnt", {24'd0, err_cnt}, 32'd0);
      check("mr_err_adr", err_adr, 32'd0);
      check("mr_m_dat_r", m_dat_r, 32'd0);
      check("mr_s_adr", s_adr, 32'd0);
      @(negedge sys_clk);
      m_cyc = 1'b0;
      rst = 1'b0;
      run_xfer(32'h03300004, 1'b0, 32'h0, 0, 4'h0, 0, 5);
      check("mr_next_lat", r_lat, 2);
      check("mr_next_data", r_dat, 32'h12345678);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
